// File: rtl/vc_iter_divider.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned,
// val/rdy on request and response. Latency is fixed and data-independent.
module vc_iter_divider #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sd,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic               in_signed,
  input  logic [p_nbits-1:0] in_dividend,
  input  logic [p_nbits-1:0] in_divisor,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_quotient,
  output logic [p_nbits-1:0] out_remainder
);

  localparam int cw = $clog2(p_nbits + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg;
  logic [cw-1:0]      cnt_reg;
  logic [p_nbits-1:0] quo_reg;
  logic [p_nbits-1:0] rem_reg;
  logic [p_nbits-1:0] div_reg;
  logic [p_nbits-1:0] dividend_reg;
  logic               qneg_reg;
  logic               rneg_reg;
  logic               div0_reg;
  logic               in_rdy_reg;
  logic               out_val_reg;

  // The security domain only labels the data; it never steers the datapath.
  logic unused_sd;
  assign unused_sd = sd;

  logic               dividend_neg;
  logic               divisor_neg;
  logic [p_nbits-1:0] dividend_abs;
  logic [p_nbits-1:0] divisor_abs;

  assign dividend_neg = in_signed & in_dividend[p_nbits-1];
  assign divisor_neg  = in_signed & in_divisor[p_nbits-1];
  assign dividend_abs = dividend_neg ? -in_dividend : in_dividend;
  assign divisor_abs  = divisor_neg  ? -in_divisor  : in_divisor;

  // One restoring step; the extra top bit keeps 2*rem+1 from overflowing.
  logic [p_nbits:0]   rem_sh;
  logic [p_nbits:0]   trial;
  logic [p_nbits-1:0] rem_step;
  logic [p_nbits-1:0] quo_step;
  logic [p_nbits-1:0] quo_fix;
  logic [p_nbits-1:0] rem_fix;

  assign rem_sh   = {rem_reg, quo_reg[p_nbits-1]};
  assign trial    = rem_sh - {1'b0, div_reg};
  assign rem_step = trial[p_nbits] ? rem_sh[p_nbits-1:0] : trial[p_nbits-1:0];
  assign quo_step = {quo_reg[p_nbits-2:0], ~trial[p_nbits]};

  // Divide-by-zero overrides sign correction entirely.
  assign quo_fix = div0_reg ? {p_nbits{1'b1}} : (qneg_reg ? -quo_step : quo_step);
  assign rem_fix = div0_reg ? dividend_reg   : (rneg_reg ? -rem_step : rem_step);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      div_reg      <= '0;
      dividend_reg <= '0;
      qneg_reg     <= 1'b0;
      rneg_reg     <= 1'b0;
      div0_reg     <= 1'b0;
      in_rdy_reg   <= 1'b1;
      out_val_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_val && in_rdy_reg) begin
            quo_reg      <= dividend_abs;
            div_reg      <= divisor_abs;
            rem_reg      <= '0;
            qneg_reg     <= in_signed & (in_dividend[p_nbits-1] ^ in_divisor[p_nbits-1]);
            rneg_reg     <= dividend_neg;
            div0_reg     <= (in_divisor == '0);
            dividend_reg <= in_dividend;
            cnt_reg      <= cw'(p_nbits);
            in_rdy_reg   <= 1'b0;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg - cw'(1);
          if (cnt_reg == cw'(1)) begin
            quo_reg     <= quo_fix;
            rem_reg     <= rem_fix;
            out_val_reg <= 1'b1;
            state_reg   <= DONE;
          end else begin
            quo_reg <= quo_step;
            rem_reg <= rem_step;
          end
        end
        DONE: begin
          if (out_rdy) begin
            out_val_reg <= 1'b0;
            in_rdy_reg  <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: begin
          out_val_reg <= 1'b0;
          in_rdy_reg  <= 1'b1;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign in_rdy        = in_rdy_reg;
  assign out_val       = out_val_reg;
  assign out_quotient  = quo_reg;
  assign out_remainder = rem_reg;

endmodule

// File: tb/tb_vc_iter_divider.sv
// Directed bench for vc_iter_divider: arithmetic corners, latency,
// backpressure and mid-operation reset, against hand-computed results.
module tb_vc_iter_divider;

  localparam int P = 32;

  logic         clk;
  logic         reset;
  logic         sd;
  logic         in_val;
  logic         in_rdy;
  logic         in_signed;
  logic [P-1:0] in_dividend;
  logic [P-1:0] in_divisor;
  logic         out_val;
  logic         out_rdy;
  logic [P-1:0] out_quotient;
  logic [P-1:0] out_remainder;

  int checks   = 0;
  int failures = 0;

  vc_iter_divider #(.p_nbits(P)) dut (
    .clk          (clk),
    .reset        (reset),
    .sd           (sd),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_signed    (in_signed),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_quotient (out_quotient),
    .out_remainder(out_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for the response, optionally stall it for
  // `hold` cycles while poking in_val, then complete the handshake.
  task automatic run(input string tag, input bit sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] q,
                     input logic [31:0] r, input int hold);
    int edges;
    bit rdy_seen;
    check({tag, "_in_rdy_idle"}, 32'(in_rdy), 32'd1);
    in_val      = 1'b1;
    in_signed   = sgn;
    in_dividend = a;
    in_divisor  = b;
    out_rdy     = (hold == 0);
    @(posedge clk); #1;
    in_val      = 1'b0;
    in_signed   = ~sgn;
    in_dividend = 32'hDEAD_BEEF;
    in_divisor  = 32'h0;
    edges    = 0;
    rdy_seen = 1'b0;
    while (!out_val && edges < 40) begin
      if (in_rdy) rdy_seen = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    // Handshake cycle plus 32 more edges = response in the 33rd cycle.
    check({tag, "_latency"}, 32'(edges), 32'(P));
    check({tag, "_in_rdy_busy"}, 32'({rdy_seen, in_rdy}), 32'd0);
    check({tag, "_q"}, out_quotient, q);
    check({tag, "_r"}, out_remainder, r);
    for (int i = 0; i < hold; i++) begin
      in_val      = 1'b1;
      in_dividend = 32'd1;
      in_divisor  = 32'd1;
      @(posedge clk); #1;
      check({tag, "_hold_val"}, 32'(out_val), 32'd1);
      check({tag, "_hold_q"}, out_quotient, q);
      check({tag, "_hold_r"}, out_remainder, r);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check({tag, "_out_val_after"}, 32'(out_val), 32'd0);
    check({tag, "_in_rdy_after"}, 32'(in_rdy), 32'd1);
    $display("txn %s a=%h b=%h signed=%0d q=%h r=%h lat=%0d", tag, a, b, sgn,
             q, r, edges);
  endtask

  initial begin
    int edges;
    bit val_seen;
    reset       = 1'b0;
    sd          = 1'b0;
    in_val      = 1'b0;
    in_signed   = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_rdy     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_q", out_quotient, 32'd0);
    check("rst_r", out_remainder, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run("u100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         0);
    run("s-7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  0);
    run("s7_-2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         0);
    run("s-100_-7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  0);
    run("u5_0",     1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         0);
    run("s-5_0",    1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  0);
    run("s_ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         0);
    run("u_ovf",    1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  0);
    run("u_max_16", 1'b0, 32'hFFFFFFFF,  32'd16,        32'h0FFFFFFF,  32'd15,        0);
    run("bp100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         5);

    // Abort 100/7 with a one-cycle reset pulse ten cycles into CALC.
    in_val      = 1'b1;
    in_signed   = 1'b0;
    in_dividend = 32'd100;
    in_divisor  = 32'd7;
    @(posedge clk); #1;
    in_val = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_async_in_rdy", 32'(in_rdy), 32'd1);
    check("abort_async_out_val", 32'(out_val), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    val_seen = 1'b0;
    for (edges = 0; edges < 40; edges++) begin
      if (out_val) val_seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_response", 32'(val_seen), 32'd0);
    check("abort_in_rdy", 32'(in_rdy), 32'd1);
    run("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vc_iter_divider.md
Name: vc_iter_divider

Overview:
- Iterative restoring integer divider with val/rdy handshakes on both the request and response sides.
- It is the inverse-operation companion to the team's multiply/adder datapath components, and serves as the DIV/REM unit of the processor's long-latency execute path.
- It computes one quotient bit per cycle and supports signed and unsigned operands.
- All data ports carry the security label {Domain sd}; sd itself is {L}.

Parameters:
- p_nbits, 32, operand/result width in bits (must be >= 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- sd  in  1  security domain select, label {L}; held constant by the requester for the whole transaction.
- in_val  in  1  request valid.
- in_rdy  out  1  divider can accept a request.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_dividend  in  p_nbits  dividend, label {Domain sd}.
- in_divisor  in  p_nbits  divisor, label {Domain sd}.
- out_val  out  1  response valid.
- out_rdy  in  1  consumer accepts response.
- out_quotient  out  p_nbits  quotient, label {Domain sd}.
- out_remainder  out  p_nbits  remainder, label {Domain sd}.

Behaviour:
- FSM states: IDLE, CALC, DONE.
- Reset (reset==0, async) forces IDLE and clears the counter and the quotient/remainder registers. Reset values: in_rdy=1, out_val=0, out_quotient=0, out_remainder=0.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_val&&in_rdy the block captures:
    - |dividend| into the quotient shift register;
    - |divisor| into the divisor register;
    - the remainder register is cleared;
    - quotient sign = in_signed && (dividend MSB ^ divisor MSB);
    - remainder sign = in_signed && dividend MSB;
    - a div-by-zero flag (divisor==0);
    - the original dividend.
  - Counter loads p_nbits; next state CALC.
  - Absolute value applies only when in_signed=1; unsigned operands pass through unchanged.
- CALC:
  - in_rdy=0, out_val=0.
  - Each edge performs one restoring step:
    - shift {rem,quo} left 1;
    - trial = rem - divisor, computed in p_nbits+1 bits;
    - if trial is non-negative, rem=trial and quo LSB=1; else quo LSB=0.
  - Counter decrements; the edge at which the counter==1 moves to DONE.
- DONE:
  - out_val=1, in_rdy=0.
  - out_quotient and out_remainder are sign-corrected (negated per the captured sign flags) when entering DONE. They are registered and stable while out_val&&!out_rdy.
  - On out_val&&out_rdy, next state is IDLE.
  - There is no request overlap: a new request cannot be accepted in the same cycle as the response handshake.
- Latency: the response is visible exactly p_nbits+1 cycles after the request-handshake cycle (33 for p_nbits=32). Latency is data-independent, so there are no early-out timing channels.
- Divide by zero, signed or unsigned: quotient = all ones; remainder = original dividend. This overrides sign correction.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0. This falls out of the unsigned core plus negation and needs no special case.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- Reset asserted mid-CALC or mid-DONE aborts the operation. No response is produced, and the block is in IDLE with in_rdy=1 after reset deassertion.
- in_val while not in IDLE is ignored; operand inputs are not sampled outside the IDLE handshake.
- sd changing mid-transaction is a requester protocol violation; the block does not check for it.

Test Plan:
- Unsigned 100/7, out_rdy=1 -> out_val rises 33 cycles after the in handshake; q=14, r=2; in_rdy low throughout CALC/DONE and high the cycle after.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Signed 7/-2 -> q=0xFFFFFFFD, r=1.
- Divide by zero: unsigned 5/0 -> q=0xFFFFFFFF, r=5. Signed -5/0 -> q=0xFFFFFFFF, r=0xFFFFFFFB.
- Overflow: signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0. The same operands unsigned -> q=0, r=0x80000000.
- Backpressure: 100/7 with out_rdy=0 for 5 cycles after out_val -> outputs held stable at 14/2, in_val pulses ignored, a single handshake when out_rdy=1, then IDLE.
- Reset mid-CALC: drop reset for 1 cycle 10 cycles into 100/7 -> out_val never asserts for it, in_rdy=1 immediately. A follow-up 9/3 returns q=3, r=0 with the full 33-cycle latency.
